// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle control unit.
// CONTROL_UNIT_TRAP_EN adds the HALT state used to trap illegal opcodes.
package control_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_EXEC_R   = 4'd3,
      ST_EXEC_I   = 4'd4,
      ST_ALU_WB   = 4'd5,
      ST_MEM_ADDR = 4'd6,
      ST_MEM_RD   = 4'd7,
      ST_MEM_WB   = 4'd8,
      ST_MEM_WR   = 4'd9,
      ST_BRANCH   = 4'd10
`ifdef CONTROL_UNIT_TRAP_EN
      , ST_HALT   = 4'd11
`endif
   } state_t;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_SD = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   localparam logic [1:0] SRCB_REG    = 2'd0;
   localparam logic [1:0] SRCB_4      = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [1:0] PCSRC_ALU  = 2'd0;
   localparam logic [1:0] PCSRC_AOUT = 2'd1;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       alu_src_a;
      logic       load_aout;
      logic       reg_write;
      logic       load_reg_a;
      logic       load_reg_b;
      logic       mem_to_reg;
      logic       dmem_op;
      logic       load_mdr;
      logic       imem_read;
      logic       ir_write;
      logic [1:0] pc_source;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctrl_t;

   typedef struct packed {
      logic r;
      logic i;
      logic ld;
      logic sd;
      logic br;
   } iclass_t;

   // ALU_WB keeps the ALU selects of the preceding EXEC state so the result stays stable.
   function automatic ctrl_t ctrl_for(input state_t s, input ctrl_t prev);
      ctrl_t c;
      c = '0;
      case (s)
         ST_FETCH: begin
            c.imem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
            c.alu_src_b = SRCB_4; c.alu_op = ALU_ADD; c.pc_source = PCSRC_ALU;
         end
         ST_DECODE: begin
            c.load_reg_a = 1'b1; c.load_reg_b = 1'b1; c.load_aout = 1'b1;
            c.alu_src_b = SRCB_IMM_SH; c.alu_op = ALU_ADD;
         end
         ST_EXEC_R: begin
            c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REG; c.alu_op = ALU_FUNCT; c.load_aout = 1'b1;
         end
         ST_EXEC_I: begin
            c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_FUNCT; c.load_aout = 1'b1;
         end
         ST_ALU_WB: begin
            c.alu_src_a = prev.alu_src_a; c.alu_src_b = prev.alu_src_b; c.alu_op = prev.alu_op;
            c.reg_write = 1'b1;
         end
         ST_MEM_ADDR: begin
            c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_ADD; c.load_aout = 1'b1;
         end
         ST_MEM_RD: begin
            c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_ADD; c.load_mdr = 1'b1;
         end
         ST_MEM_WB: begin
            c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
         end
         ST_MEM_WR: begin
            c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_ADD; c.dmem_op = 1'b1;
         end
         ST_BRANCH: begin
            c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REG; c.alu_op = ALU_SUB;
            c.pc_write_cond = 1'b1; c.pc_source = PCSRC_AOUT;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit (master) and the processing datapath (slave).
interface control_unit_if #(parameter int CNT_W = 32);
   logic [31:0]      instruction;
   logic             PCWrite, PCWriteCond, ALUSrcA, LoadAOut, RegWrite, LoadRegA;
   logic             LoadRegB, MemToReg, DMemOp, LoadMDR, IMemRead, IRWrite;
   logic [1:0]       PCSource, ALUSrcB, ALUOp;
   logic [3:0]       state_dbg;
   logic [CNT_W-1:0] retired;
   logic             illegal_instr;

   modport master (
      input  instruction,
      output PCWrite, PCWriteCond, ALUSrcA, LoadAOut, RegWrite, LoadRegA,
             LoadRegB, MemToReg, DMemOp, LoadMDR, IMemRead, IRWrite,
             PCSource, ALUSrcB, ALUOp, state_dbg, retired, illegal_instr
   );

   modport slave (
      output instruction,
      input  PCWrite, PCWriteCond, ALUSrcA, LoadAOut, RegWrite, LoadRegA,
             LoadRegB, MemToReg, DMemOp, LoadMDR, IMemRead, IRWrite,
             PCSource, ALUSrcB, ALUOp, state_dbg, retired, illegal_instr
   );
endinterface

// File: rtl/control_decode.sv
// Opcode to one-hot instruction class; o_legal is low for any unsupported opcode.
module control_decode
   import control_pkg::*;
(
   input  logic [6:0] i_opcode,
   output iclass_t    o_class,
   output logic       o_legal
);

   // Classify the opcode.
   always_comb begin
      o_class = '0;
      case (i_opcode)
         OP_R:    o_class.r  = 1'b1;
         OP_I:    o_class.i  = 1'b1;
         OP_LD:   o_class.ld = 1'b1;
         OP_SD:   o_class.sd = 1'b1;
         OP_BR:   o_class.br = 1'b1;
         default: o_class    = '0;
      endcase
      o_legal = |o_class;
   end

endmodule

// File: rtl/control_unit.sv
// Multicycle Moore control FSM with retired-instruction counter.
// CONTROL_UNIT_TRAP_EN: illegal opcodes halt the FSM and raise illegal_instr.
module control_unit
   import control_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic           clk,
   input  logic           reset,
   control_unit_if.master bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next;
   ctrl_t            r_ctrl;
   logic [CNT_W-1:0] r_retired;
   logic             w_retire;
   iclass_t          w_class;
   logic             w_legal;
   logic             w_unused_bits;

   assign w_unused_bits = ^bus.instruction[31:7];

   control_decode u_decode (
      .i_opcode (bus.instruction[6:0]),
      .o_class  (w_class),
      .o_legal  (w_legal)
   );

   // Next-state selection and retire detection.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   w_next = ST_FETCH;
         ST_FETCH:  w_next = ST_DECODE;
         ST_DECODE: begin
            if (!w_legal) begin
`ifdef CONTROL_UNIT_TRAP_EN
               w_next = ST_HALT;
`else
               w_next = ST_FETCH;
`endif
            end else if (w_class.r) begin
               w_next = ST_EXEC_R;
            end else if (w_class.i) begin
               w_next = ST_EXEC_I;
            end else if (w_class.br) begin
               w_next = ST_BRANCH;
            end else begin
               w_next = ST_MEM_ADDR;
            end
         end
         ST_EXEC_R:   w_next = ST_ALU_WB;
         ST_EXEC_I:   w_next = ST_ALU_WB;
         ST_ALU_WB:   w_next = ST_FETCH;
         ST_MEM_ADDR: w_next = w_class.ld ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD:   w_next = ST_MEM_WB;
         ST_MEM_WB:   w_next = ST_FETCH;
         ST_MEM_WR:   w_next = ST_FETCH;
         ST_BRANCH:   w_next = ST_FETCH;
`ifdef CONTROL_UNIT_TRAP_EN
         ST_HALT:     w_next = ST_HALT;
`endif
         default:     w_next = ST_IDLE;
      endcase
      w_retire = (w_next == ST_FETCH) &&
                 (r_state inside {ST_ALU_WB, ST_MEM_WB, ST_MEM_WR, ST_BRANCH});
   end

   // State register; controls are registered from the next state so they align with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_ctrl  <= '0;
      end else begin
         r_state <= w_next;
         r_ctrl  <= ctrl_for(w_next, r_ctrl);
      end
   end

   // Retired-instruction counter, wraps naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_retired <= '0;
      end else if (w_retire) begin
         r_retired <= r_retired + CNT_ONE;
      end else begin
         r_retired <= r_retired;
      end
   end

`ifdef CONTROL_UNIT_TRAP_EN
   logic r_illegal;

   // Sticky trap flag, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= (w_next == ST_HALT);
      end
   end

   assign bus.illegal_instr = r_illegal;
`else
   assign bus.illegal_instr = 1'b0;
`endif

   assign bus.PCWrite     = r_ctrl.pc_write;
   assign bus.PCWriteCond = r_ctrl.pc_write_cond;
   assign bus.ALUSrcA     = r_ctrl.alu_src_a;
   assign bus.LoadAOut    = r_ctrl.load_aout;
   assign bus.RegWrite    = r_ctrl.reg_write;
   assign bus.LoadRegA    = r_ctrl.load_reg_a;
   assign bus.LoadRegB    = r_ctrl.load_reg_b;
   assign bus.MemToReg    = r_ctrl.mem_to_reg;
   assign bus.DMemOp      = r_ctrl.dmem_op;
   assign bus.LoadMDR     = r_ctrl.load_mdr;
   assign bus.IMemRead    = r_ctrl.imem_read;
   assign bus.IRWrite     = r_ctrl.ir_write;
   assign bus.PCSource    = r_ctrl.pc_source;
   assign bus.ALUSrcB     = r_ctrl.alu_src_b;
   assign bus.ALUOp       = r_ctrl.alu_op;
   assign bus.state_dbg   = r_state;
   assign bus.retired     = r_retired;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-instruction expected cycle rows are queued
// by the driver and compared by a negedge monitor.
module tb_control_unit;
   import control_pkg::*;

   localparam int CNT_W = 32;

   typedef struct packed {
      logic [3:0]       st;
      logic             pcw, pcwc, srca, ldaout, regw, lda, ldb, m2r, dmem, ldmdr, imr, irw;
      logic [1:0]       pcsrc, srcb, aluop;
      logic             ill;
      logic [CNT_W-1:0] ret;
   } row_t;

   logic clk = 1'b0;
   logic reset;
   row_t sb_q[$];
   logic [CNT_W-1:0] exp_retired;
   int n_checks = 0;
   int n_fail = 0;

   control_unit_if #(.CNT_W(CNT_W)) bus ();
   control_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus.master));

   always #5 clk = ~clk;

   function automatic row_t blank(input state_t s);
      row_t r;
      r = '0;
      r.st = s;
      r.ret = exp_retired;
      return r;
   endfunction

   function automatic row_t sample();
      row_t r;
      r.st = bus.state_dbg;     r.pcw = bus.PCWrite;   r.pcwc = bus.PCWriteCond;
      r.srca = bus.ALUSrcA;     r.ldaout = bus.LoadAOut; r.regw = bus.RegWrite;
      r.lda = bus.LoadRegA;     r.ldb = bus.LoadRegB;  r.m2r = bus.MemToReg;
      r.dmem = bus.DMemOp;      r.ldmdr = bus.LoadMDR; r.imr = bus.IMemRead;
      r.irw = bus.IRWrite;      r.pcsrc = bus.PCSource; r.srcb = bus.ALUSrcB;
      r.aluop = bus.ALUOp;      r.ill = bus.illegal_instr; r.ret = bus.retired;
      return r;
   endfunction

   // Expected per-cycle behaviour of one instruction, FETCH through its last state.
   task automatic push_instr(input logic [31:0] ins, input int limit, output int n);
      row_t rows[$];
      row_t r;
      bit   retires;
      retires = 1'b1;
      r = blank(ST_FETCH); r.imr = 1; r.irw = 1; r.pcw = 1; r.srcb = 2'd1; rows.push_back(r);
      r = blank(ST_DECODE); r.lda = 1; r.ldb = 1; r.ldaout = 1; r.srcb = 2'd3; rows.push_back(r);
      case (ins[6:0])
         7'b0110011, 7'b0010011: begin
            r = blank(ins[4] && ins[5] ? ST_EXEC_R : ST_EXEC_I);
            r.srca = 1; r.ldaout = 1; r.aluop = 2'd2; r.srcb = ins[5] ? 2'd0 : 2'd2;
            rows.push_back(r);
            r = blank(ST_ALU_WB); r.srca = 1; r.aluop = 2'd2; r.srcb = ins[5] ? 2'd0 : 2'd2;
            r.regw = 1; rows.push_back(r);
         end
         7'b0000011, 7'b0100011: begin
            r = blank(ST_MEM_ADDR); r.srca = 1; r.srcb = 2'd2; r.ldaout = 1; rows.push_back(r);
            if (ins[5]) begin
               r = blank(ST_MEM_WR); r.srca = 1; r.srcb = 2'd2; r.dmem = 1; rows.push_back(r);
            end else begin
               r = blank(ST_MEM_RD); r.srca = 1; r.srcb = 2'd2; r.ldmdr = 1; rows.push_back(r);
               r = blank(ST_MEM_WB); r.regw = 1; r.m2r = 1; rows.push_back(r);
            end
         end
         7'b1100011: begin
            r = blank(ST_BRANCH); r.srca = 1; r.aluop = 2'd1; r.pcwc = 1; r.pcsrc = 2'd1;
            rows.push_back(r);
         end
         default: begin
            retires = 1'b0;
`ifdef CONTROL_UNIT_TRAP_EN
            for (int k = 0; k < 10; k++) begin
               r = blank(ST_HALT); r.ill = 1; rows.push_back(r);
            end
`endif
         end
      endcase
      n = (limit < rows.size()) ? limit : rows.size();
      for (int k = 0; k < n; k++) sb_q.push_back(rows[k]);
      if (retires && n == rows.size()) exp_retired = exp_retired + 1'b1;
   endtask

   task automatic run(input logic [31:0] ins);
      int n;
      bus.instruction = ins;
      push_instr(ins, 100, n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compare every cycle that has an expected row queued.
   always @(negedge clk) begin
      row_t e, a;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         a = sample();
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL ctrl_row exp_state=%0d act_state=%0d act=%h required=%h", e.st, a.st, a, e);
         end
      end
   end

   logic [6:0] ops[5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};

   initial begin
      logic [31:0] ins;
      logic [6:0]  op;
      int n;
      reset = 1'b0;
      bus.instruction = 32'd0;
      exp_retired = '0;
      #1;
      sb_q.push_back(blank(ST_IDLE));
      sb_q.push_back(blank(ST_IDLE));
      #21 reset = 1'b1;
      @(posedge clk);
      #1;

      run(32'h00208033);
      run(32'h0000B103);
      run(32'h00113023);
      run(32'h00208063);
`ifndef CONTROL_UNIT_TRAP_EN
      run(32'h0000007F);
      run(32'h00208033);
`endif

      for (int i = 0; i < 40; i++) begin
         ins = $urandom;
`ifdef CONTROL_UNIT_TRAP_EN
         op = ops[$urandom_range(0, 4)];
`else
         if ($urandom_range(0, 5) == 0) begin
            op = 7'($urandom_range(0, 127));
            while (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011})
               op = 7'($urandom_range(0, 127));
         end else begin
            op = ops[$urandom_range(0, 4)];
         end
`endif
         ins[6:0] = op;
         run(ins);
      end

      // Abort an LD in MEM_RD with reset.
      bus.instruction = 32'h0000B103;
      push_instr(32'h0000B103, 4, n);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      #1 reset = 1'b0;
      exp_retired = '0;
      sb_q.push_back(blank(ST_IDLE));
      @(negedge clk);
      #2 reset = 1'b1;
      force dut.r_retired = '1;
      #1 release dut.r_retired;
      exp_retired = '1;
      @(posedge clk);
      #1;
      run(32'h00208063);
      run(32'h00208033);

`ifdef CONTROL_UNIT_TRAP_EN
      run(32'h0000007F);
`endif

      for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d required=0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
